farm_road_sensor: RTL
=====================

# farm_road_sensor

Vehicle detector for the farm-road approach. It produces the `Car` request that the highway/farm traffic-light controller consumes, and it closes the loop by reading the controller's farm-green lamp. A raw inductive-loop signal is synchronized and debounced, each debounced arrival increments a waiting-vehicle queue, and farm-green time drains that queue. `Car` is asserted whenever the queue is non-empty.

## Interface
Parameters:
- `DEBOUNCE`, default 3: consecutive synchronized samples needed to accept a loop edge. Legal range 2..15.
- `PASS_CYCLES`, default 2: farm-green cycles per departing vehicle. Legal range 1..15.

Ports:
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Loop`  in  1  raw loop-detector output, asynchronous and may bounce.
- `FG`  in  1  farm-green lamp from the light controller; synchronous to `Clk`.
- `Car`  out  1  registered; 1 when `QueueCount` != 0.
- `QueueCount`  out  4  registered count of waiting vehicles.
- `Overflow`  out  1  sticky; set when an arrival is dropped because the queue is full.

## Operation
- **Synchronizer.** Two flops, `sync_a <= Loop` and `sync_b <= sync_a`. Only `sync_b` feeds the FSM.
- **Debounce FSM.** States IDLE, ARRIVE, PRESENT, DEPART, plus a 4-bit counter `cnt`.
  - IDLE: if `sync_b`=1, go to ARRIVE with `cnt`<=1.
  - ARRIVE: if `sync_b`=0, go to IDLE (glitch, no count). Else if `cnt`==`DEBOUNCE`-1, go to PRESENT and raise arrival strobe `inc`. Else `cnt`++.
  - PRESENT: if `sync_b`=0, go to DEPART with `cnt`<=1.
  - DEPART: if `sync_b`=1, go back to PRESENT (no new arrival). Else if `cnt`==`DEBOUNCE`-1, go to IDLE. Else `cnt`++.
- **Drain.** Uses a 4-bit `pass_cnt`.
  - `FG`=0: `pass_cnt`<=0.
  - `FG`=1 and `pass_cnt`==`PASS_CYCLES`-1: raise departure strobe `dec` only if `QueueCount`>0, and set `pass_cnt`<=0.
  - Otherwise with `FG`=1: `pass_cnt`++.
- **Queue update** (applied in the same edge as the strobes):
  - `inc` and `dec` together: `QueueCount` unchanged.
  - `inc` only: if `QueueCount`==15, hold at 15 and set `Overflow`<=1; else increment.
  - `dec` only: decrement. `dec` cannot occur at 0, so there is no underflow.
- **Car.** `Car` <= (next `QueueCount` != 0), so `Car` changes on the same edge as `QueueCount`.
- **Overflow** clears only on `Reset`.

## Timing
- **Reset values:** `Car`=0, `QueueCount`=0, `Overflow`=0. Also FSM=IDLE, `cnt`=0, `pass_cnt`=0, `sync_a`=`sync_b`=0.
- **Reset mid-operation:** any state or partial count is abandoned. The edge after `Reset` deasserts behaves as IDLE with an empty queue.
- **Arrival latency:** `Loop`=1 sampled at edge N, held steady, gives `QueueCount` and `Car` updated at edge N+`DEBOUNCE`+1. Default: N+4.
- **Minimum accepted pulse:** `sync_b` must be 1 for `DEBOUNCE` consecutive edges. Any shorter pulse is ignored.
- **Departure:** with `FG` continuously 1 starting at edge M, decrements occur at M+`PASS_CYCLES`-1, M+2·`PASS_CYCLES`-1, and so on.
  - An `FG` drop cancels the partial pass interval.
  - `Car` falls on the same edge that `QueueCount` reaches 0.
- **Loop drop while PRESENT:** a drop shorter than `DEBOUNCE` samples does not re-count the same vehicle.

## Test plan
- **Reset:** drive `Loop`=1 and `FG`=1 and hold `Reset` high for 3 cycles -> `Car`=0, `QueueCount`=0, `Overflow`=0 throughout. After release, the first increment lands 4 edges later.
- **Single arrival:** `Loop` rises before edge 10 and stays high; `FG`=0 -> `QueueCount` goes 0->1 and `Car` 0->1 at edge 14. A 1-cycle and a 2-cycle `Loop` pulse each leave `QueueCount`=0.
- **Bounce on departure:** vehicle counted (`QueueCount`=1). `Loop` goes 0 for 2 samples, 1 for 1, then 0 for 5 -> `QueueCount` stays 1 and the FSM returns to IDLE. A second clean pulse makes `QueueCount`=2.
- **Drain:** `QueueCount`=3, `FG`=1 from edge 20 -> `QueueCount` reads 2 at edge 21, 1 at edge 23, and 0 at edge 25 with `Car` falling at 25. `FG` dropping at edge 22 instead leaves `QueueCount`=2.
- **Simultaneous events:** arrange `inc` and `dec` on the same edge at `QueueCount`=5 -> `QueueCount` stays 5 and `Car` stays 1.
- **Saturation:** 16 clean arrivals -> `QueueCount`=15 and `Overflow`=1 after the 16th. `Overflow` stays 1 after draining to 0 and clears only on `Reset`.

Source files
------------

// File: rtl/farm_road_sensor.sv
// farm_road_sensor
//   Vehicle detector for the farm-road approach. A raw inductive-loop signal
//   is synchronized and debounced. Each accepted arrival increments a
//   waiting-vehicle queue, and farm-green time drains that queue at one
//   vehicle per PASS_CYCLES green cycles. Car requests service whenever the
//   queue is non-empty.
//
// Parameters
//   DEBOUNCE     consecutive synchronized samples to accept a loop edge (2..15)
//   PASS_CYCLES  farm-green cycles per departing vehicle (1..15)
//
// Ports
//   Clk         in   system clock, rising edge
//   Reset       in   synchronous, active-high
//   Loop        in   raw loop detector output (asynchronous, may bounce)
//   FG          in   farm-green lamp from the light controller (sync to Clk)
//   Car         out  registered, 1 when QueueCount != 0
//   QueueCount  out  registered count of waiting vehicles (0..15)
//   Overflow    out  sticky, set when an arrival is dropped at a full queue
module farm_road_sensor #(
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned PASS_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Loop,
  input  logic       FG,
  output logic       Car,
  output logic [3:0] QueueCount,
  output logic       Overflow
);

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE - 1);
  localparam logic [3:0] PASS_LAST = 4'(PASS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARRIVE,
    PRESENT,
    DEPART
  } state_t;

  // Two-flop synchronizer for the asynchronous loop input.
  logic sync_a;
  logic sync_b;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= Loop;
      sync_b <= sync_a;
    end
  end

  // Debounce FSM
  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       inc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inc       = 1'b0;
    case (state)
      IDLE: begin
        if (sync_b) begin
          state_nxt = ARRIVE;
          cnt_nxt   = 4'd1;
        end
      end
      ARRIVE: begin
        if (!sync_b) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = PRESENT;
          inc       = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      PRESENT: begin
        if (!sync_b) begin
          state_nxt = DEPART;
          cnt_nxt   = 4'd1;
        end
      end
      DEPART: begin
        // A return to 1 here is the same vehicle bouncing, not a new arrival.
        if (sync_b) begin
          state_nxt = PRESENT;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Drain: one departure per PASS_CYCLES consecutive farm-green cycles.
  logic [3:0] pass_cnt;
  logic [3:0] pass_cnt_nxt;
  logic       dec;

  always_comb begin
    pass_cnt_nxt = pass_cnt;
    dec          = 1'b0;
    if (!FG) begin
      pass_cnt_nxt = '0;
    end else if (pass_cnt == PASS_LAST) begin
      pass_cnt_nxt = '0;
      dec          = (QueueCount != 4'd0);
    end else begin
      pass_cnt_nxt = pass_cnt + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pass_cnt <= '0;
    end else begin
      pass_cnt <= pass_cnt_nxt;
    end
  end

  // Queue update, applied on the same edge as the strobes.
  logic [3:0] queue_nxt;
  logic       overflow_nxt;

  always_comb begin
    queue_nxt    = QueueCount;
    overflow_nxt = Overflow;
    if (inc && !dec) begin
      if (QueueCount == 4'd15) begin
        overflow_nxt = 1'b1;
      end else begin
        queue_nxt = QueueCount + 4'd1;
      end
    end else if (dec && !inc) begin
      queue_nxt = QueueCount - 4'd1;
    end
  end

  // Car is derived from the next count so it moves on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      QueueCount <= '0;
      Car        <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      QueueCount <= queue_nxt;
      Car        <= (queue_nxt != 4'd0);
      Overflow   <= overflow_nxt;
    end
  end

endmodule
